// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b - bin, LSB first, one bit per clock,
// valid/ready on both sides. Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_sh_r, b_sh_r, res_r, res_s;
    logic [CNT_W-1:0] cnt_r;
    logic             br_r, br_s, d_s, last_s;
    logic [WIDTH-1:0] diff_r;
    logic             bout_r;
`ifdef SERIAL_SUB_OVF_EN
    logic             ovf_r;
`endif

    function automatic logic fs_diff(input logic x, input logic y, input logic br);
        return x ^ y ^ br;
    endfunction

    function automatic logic fs_borrow(input logic x, input logic y, input logic br);
        return (~x & y) | (~x & br) | (y & br);
    endfunction

    // Full-subtractor cell on the current LSBs and the result word after this shift
    always_comb begin
        d_s    = fs_diff(a_sh_r[0], b_sh_r[0], br_r);
        br_s   = fs_borrow(a_sh_r[0], b_sh_r[0], br_r);
        res_s  = {d_s, res_r[WIDTH-1:1]};
        last_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_s = SHIFT;
                else          state_s = IDLE;
            end
            SHIFT: begin
                if (last_s) state_s = DONE;
                else        state_s = SHIFT;
            end
            DONE: begin
                if (out_ready) state_s = IDLE;
                else           state_s = DONE;
            end
            default: state_s = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Operand/result shift registers, borrow FF, bit counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_r <= '0;
            b_sh_r <= '0;
            res_r  <= '0;
            br_r   <= 1'b0;
            cnt_r  <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_sh_r <= a;
                        b_sh_r <= b;
                        br_r   <= bin;
                        cnt_r  <= '0;
                    end
                end
                SHIFT: begin
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    res_r  <= res_s;
                    br_r   <= br_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        diff_r <= res_s;
                        bout_r <= br_s;
`ifdef SERIAL_SUB_OVF_EN
                        // br_r here is the borrow into the MSB cell
                        ovf_r  <= br_r ^ br_s;
`endif
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign out_valid = (state_r == DONE);
    assign diff      = diff_r;
    assign bout      = bout_r;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf       = ovf_r;
`endif

endmodule
